board_state_writer: RTL and testbench

- Owns the four 100-bit game boards and is the write side of the board interface; the board drawing datapath is the read side.
- Turns one-cycle player action strobes into cursor moves, ship placements and shots.
- Computes the placement and move validity flags.
- Requests a redraw through an UPDATE/FINISH handshake after every accepted action.
- Sits between the input debounce/edge logic and the board drawing datapath.

---
 rtl/board_state_writer_pkg.sv | 33 +++
 rtl/board_state_writer_ship_mask_gen.sv | 25 ++
 rtl/board_state_writer.sv | 163 ++++++++++++++++
 tb/tb_board_state_writer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_state_writer_pkg.sv
// rtl/board_state_writer_pkg.sv - shared states, board geometry and ship table for board_state_writer
package board_state_writer_pkg;

  localparam int NUM_SHIPS        = 5;
  localparam int TOTAL_SHIP_CELLS = 17;
  localparam int BOARD_W          = 10;
  localparam int BOARD_CELLS      = 100;

  typedef enum logic [2:0] {
    S_PLACE_P1,
    S_PLACE_P2,
    S_FIRE,
    S_WAIT_DRAW,
    S_GAME_OVER
  } state_t;

  function automatic logic [2:0] ship_len(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'd5;
      3'd1:    return 3'd4;
      3'd2:    return 3'd3;
      3'd3:    return 3'd3;
      3'd4:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // x + 10*y built from shifts so no multiplier is needed
  function automatic logic [6:0] cell_index(input logic [3:0] x, input logic [3:0] y);
    return {3'b000, x} + {y, 3'b000} + {2'b00, y, 1'b0};
  endfunction

endpackage

// File: rtl/board_state_writer_ship_mask_gen.sv
// rtl/board_state_writer_ship_mask_gen.sv - combinational footprint of the ship being placed
module ship_mask_gen
  import board_state_writer_pkg::*;
(
  input  logic [3:0]             x,
  input  logic [3:0]             y,
  input  logic [2:0]             len,
  input  logic                   rotate,
  output logic [BOARD_CELLS-1:0] mask
);

  logic [4:0] x_end;
  logic [4:0] y_end;

  assign x_end = {1'b0, x} + {2'b00, len};
  assign y_end = {1'b0, y} + {2'b00, len};

  for (genvar c = 0; c < BOARD_CELLS; c++) begin : g_cell
    localparam logic [4:0] CX = 5'(c % BOARD_W);
    localparam logic [4:0] CY = 5'(c / BOARD_W);
    assign mask[c] = rotate ? (CX == {1'b0, x} && CY >= {1'b0, y} && CY < y_end)
                            : (CY == {1'b0, y} && CX >= {1'b0, x} && CX < x_end);
  end

endmodule

// File: rtl/board_state_writer.sv
// rtl/board_state_writer.sv - write side of the board interface: cursor, placement, shots, redraw handshake
module board_state_writer
  import board_state_writer_pkg::*;
(
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   LEFT,
  input  logic                   RIGHT,
  input  logic                   UP,
  input  logic                   DOWN,
  input  logic                   ROTATE_PRESS,
  input  logic                   CONFIRM,
  input  logic                   FINISH,
  output logic                   UPDATE,
  output logic [BOARD_CELLS-1:0] PLAYER1_ship_board,
  output logic [BOARD_CELLS-1:0] PLAYER1_guess_board,
  output logic [BOARD_CELLS-1:0] PLAYER2_ship_board,
  output logic [BOARD_CELLS-1:0] PLAYER2_guess_board,
  output logic [3:0]             x_out,
  output logic [3:0]             y_out,
  output logic                   rotate,
  output logic [2:0]             player1_ship_length,
  output logic [2:0]             player2_ship_length,
  output logic                   CHOOSE_SHIP,
  output logic                   PLAYER1_MOVE,
  output logic                   PLAYER1_VALID_PLACEMENT,
  output logic                   PLAYER2_VALID_PLACEMENT,
  output logic                   VALID_MOVE,
  output logic                   LAST_HIT,
  output logic                   GAME_OVER,
  output logic                   WINNER
);

  state_t                 state, state_n, ret_state, ret_n, phase;
  logic [3:0]             x_n, y_n, max_x, max_y, max_x_r, max_y_r;
  logic                   rot_n, p1_move_n, update_n, last_hit_n, game_over_n, winner_n;
  logic [2:0]             ship_idx, idx_n, len;
  logic [4:0]             hit1, hit2, hit1_n, hit2_n, cur_hit;
  logic [BOARD_CELLS-1:0] p1s_n, p1g_n, p2s_n, p2g_n, mask;
  logic [6:0]             cidx;
  logic                   placing, valid_place, guessed, opp_ship, win, any_act;

  // While waiting for the redraw, flags still describe the phase we will return to
  assign phase   = (state == S_WAIT_DRAW) ? ret_state : state;
  assign placing = (phase == S_PLACE_P1) || (phase == S_PLACE_P2);
  assign len     = placing ? ship_len(ship_idx) : 3'd0;

  ship_mask_gen u_mask (
    .x      (x_out),
    .y      (y_out),
    .len    (len),
    .rotate (rotate),
    .mask   (mask)
  );

  assign valid_place = (mask & ((phase == S_PLACE_P1) ? PLAYER1_ship_board : PLAYER2_ship_board)) == '0;
  assign PLAYER1_VALID_PLACEMENT = (phase == S_PLACE_P1) && valid_place;
  assign PLAYER2_VALID_PLACEMENT = (phase == S_PLACE_P2) && valid_place;
  assign CHOOSE_SHIP = placing;

  assign cidx     = cell_index(x_out, y_out);
  assign guessed  = PLAYER1_MOVE ? PLAYER1_guess_board[cidx] : PLAYER2_guess_board[cidx];
  assign opp_ship = PLAYER1_MOVE ? PLAYER2_ship_board[cidx] : PLAYER1_ship_board[cidx];
  assign cur_hit  = PLAYER1_MOVE ? hit1 : hit2;
  assign win      = opp_ship && (cur_hit == 5'(TOTAL_SHIP_CELLS - 1));
  assign VALID_MOVE = CHOOSE_SHIP ? (PLAYER1_VALID_PLACEMENT | PLAYER2_VALID_PLACEMENT) : ~guessed;

  assign player1_ship_length = (phase == S_PLACE_P1) ? len : 3'd0;
  assign player2_ship_length = (phase == S_PLACE_P2) ? len :
                               (phase == S_PLACE_P1) ? ship_len(3'd0) : 3'd0;

  // Limits for the current orientation and for the orientation after a rotate
  assign max_x   = (placing && !rotate) ? 4'd10 - {1'b0, len} : 4'd9;
  assign max_y   = (placing &&  rotate) ? 4'd10 - {1'b0, len} : 4'd9;
  assign max_x_r = (placing &&  rotate) ? 4'd10 - {1'b0, len} : 4'd9;
  assign max_y_r = (placing && !rotate) ? 4'd10 - {1'b0, len} : 4'd9;

  assign any_act = CONFIRM | ROTATE_PRESS | LEFT | RIGHT | UP | DOWN;

  always_comb begin
    state_n = state;        ret_n = ret_state;
    x_n = x_out;            y_n = y_out;          rot_n = rotate;
    idx_n = ship_idx;       p1_move_n = PLAYER1_MOVE;
    p1s_n = PLAYER1_ship_board;  p1g_n = PLAYER1_guess_board;
    p2s_n = PLAYER2_ship_board;  p2g_n = PLAYER2_guess_board;
    hit1_n = hit1;          hit2_n = hit2;
    update_n = 1'b0;        last_hit_n = LAST_HIT;
    game_over_n = GAME_OVER; winner_n = WINNER;
    case (state)
      S_WAIT_DRAW: if (FINISH) state_n = ret_state;
      S_GAME_OVER: ;
      default: if (any_act) begin
        update_n = 1'b1;
        state_n  = S_WAIT_DRAW;
        ret_n    = state;
        if (CONFIRM) begin
          if (placing) begin
            if (valid_place) begin
              if (state == S_PLACE_P1) p1s_n = PLAYER1_ship_board | mask;
              else                     p2s_n = PLAYER2_ship_board | mask;
              if (ship_idx == 3'(NUM_SHIPS - 1)) begin
                idx_n = 3'd0;
                if (state == S_PLACE_P1) begin
                  ret_n = S_PLACE_P2; x_n = 4'd0; y_n = 4'd0; rot_n = 1'b0; p1_move_n = 1'b0;
                end else begin
                  ret_n = S_FIRE; p1_move_n = 1'b1;
                end
              end else begin
                idx_n = ship_idx + 3'd1;
              end
            end
          end else if (!guessed) begin
            if (PLAYER1_MOVE) p1g_n[cidx] = 1'b1;
            else              p2g_n[cidx] = 1'b1;
            last_hit_n = opp_ship;
            if (opp_ship) begin
              if (PLAYER1_MOVE) hit1_n = hit1 + 5'd1;
              else              hit2_n = hit2 + 5'd1;
            end
            if (win) begin
              game_over_n = 1'b1; winner_n = ~PLAYER1_MOVE; ret_n = S_GAME_OVER;
            end else begin
              p1_move_n = ~PLAYER1_MOVE;
            end
          end
        end else if (ROTATE_PRESS) begin
          rot_n = ~rotate;
          if (x_out > max_x_r) x_n = max_x_r;
          if (y_out > max_y_r) y_n = max_y_r;
        end else if (LEFT) begin
          if (x_out != 4'd0) x_n = x_out - 4'd1;
        end else if (RIGHT) begin
          if (x_out < max_x) x_n = x_out + 4'd1;
        end else if (UP) begin
          if (y_out != 4'd0) y_n = y_out - 4'd1;
        end else begin
          if (y_out < max_y) y_n = y_out + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= S_PLACE_P1;  ret_state <= S_PLACE_P1;
      x_out <= '0;  y_out <= '0;  rotate <= 1'b0;  ship_idx <= '0;
      PLAYER1_MOVE <= 1'b1;
      PLAYER1_ship_board <= '0;  PLAYER1_guess_board <= '0;
      PLAYER2_ship_board <= '0;  PLAYER2_guess_board <= '0;
      hit1 <= '0;  hit2 <= '0;
      UPDATE <= 1'b0;  LAST_HIT <= 1'b0;  GAME_OVER <= 1'b0;  WINNER <= 1'b0;
    end else begin
      state <= state_n;  ret_state <= ret_n;
      x_out <= x_n;  y_out <= y_n;  rotate <= rot_n;  ship_idx <= idx_n;
      PLAYER1_MOVE <= p1_move_n;
      PLAYER1_ship_board <= p1s_n;  PLAYER1_guess_board <= p1g_n;
      PLAYER2_ship_board <= p2s_n;  PLAYER2_guess_board <= p2g_n;
      hit1 <= hit1_n;  hit2 <= hit2_n;
      UPDATE <= update_n;  LAST_HIT <= last_hit_n;  GAME_OVER <= game_over_n;  WINNER <= winner_n;
    end
  end

endmodule

// File: tb/tb_board_state_writer.sv
// tb/tb_board_state_writer.sv - directed table and sequence checks for board_state_writer
module tb_board_state_writer;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        LEFT = 1'b0, RIGHT = 1'b0, UP = 1'b0, DOWN = 1'b0;
  logic        ROTATE_PRESS = 1'b0, CONFIRM = 1'b0, FINISH = 1'b0;
  logic        UPDATE;
  logic [99:0] p1_ship, p1_guess, p2_ship, p2_guess;
  logic [3:0]  x_out, y_out;
  logic        rotate;
  logic [2:0]  p1_len, p2_len;
  logic        CHOOSE_SHIP, PLAYER1_MOVE, P1_VALID, P2_VALID, VALID_MOVE;
  logic        LAST_HIT, GAME_OVER, WINNER;

  board_state_writer dut (
    .CLOCK                   (CLOCK),
    .RESET                   (RESET),
    .LEFT                    (LEFT),
    .RIGHT                   (RIGHT),
    .UP                      (UP),
    .DOWN                    (DOWN),
    .ROTATE_PRESS            (ROTATE_PRESS),
    .CONFIRM                 (CONFIRM),
    .FINISH                  (FINISH),
    .UPDATE                  (UPDATE),
    .PLAYER1_ship_board      (p1_ship),
    .PLAYER1_guess_board     (p1_guess),
    .PLAYER2_ship_board      (p2_ship),
    .PLAYER2_guess_board     (p2_guess),
    .x_out                   (x_out),
    .y_out                   (y_out),
    .rotate                  (rotate),
    .player1_ship_length     (p1_len),
    .player2_ship_length     (p2_len),
    .CHOOSE_SHIP             (CHOOSE_SHIP),
    .PLAYER1_MOVE            (PLAYER1_MOVE),
    .PLAYER1_VALID_PLACEMENT (P1_VALID),
    .PLAYER2_VALID_PLACEMENT (P2_VALID),
    .VALID_MOVE              (VALID_MOVE),
    .LAST_HIT                (LAST_HIT),
    .GAME_OVER               (GAME_OVER),
    .WINNER                  (WINNER)
  );

  always #5 CLOCK = ~CLOCK;

  localparam logic [5:0] A_C = 6'b100000;
  localparam logic [5:0] A_T = 6'b010000;
  localparam logic [5:0] A_L = 6'b001000;
  localparam logic [5:0] A_R = 6'b000100;
  localparam logic [5:0] A_U = 6'b000010;
  localparam logic [5:0] A_D = 6'b000001;

  typedef struct packed {
    logic [5:0] s;
    logic [3:0] ex;
    logic [3:0] ey;
    logic       er;
  } vec_t;

  vec_t        tbl [26];
  int          checks = 0, errors = 0, upd_seen = 0, bad_upd = 0;
  int          cur_x = 0, cur_y = 0;
  int          lens [5] = '{5, 4, 3, 3, 2};
  int          p1t [$];
  int          p2t [$];
  logic [99:0] exp_ship, exp_g1, exp_g2;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string name, input logic [99:0] got, input logic [99:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic act(input logic [5:0] s);
    {CONFIRM, ROTATE_PRESS, LEFT, RIGHT, UP, DOWN} = s;
    tick();
    {CONFIRM, ROTATE_PRESS, LEFT, RIGHT, UP, DOWN} = 6'b0;
    if (UPDATE !== 1'b1) bad_upd++;
    else upd_seen++;
    FINISH = 1'b1;
    tick();
    FINISH = 1'b0;
    if (UPDATE !== 1'b0) bad_upd++;
  endtask

  task automatic goto(input int tx, input int ty);
    while (cur_x < tx) begin act(A_R); cur_x++; end
    while (cur_x > tx) begin act(A_L); cur_x--; end
    while (cur_y < ty) begin act(A_D); cur_y++; end
    while (cur_y > ty) begin act(A_U); cur_y--; end
  endtask

  initial begin
    tbl[0]  = '{A_D,       4'd5, 4'd1, 1'b0};
    tbl[1]  = '{A_T,       4'd5, 4'd1, 1'b1};
    tbl[2]  = '{A_R,       4'd6, 4'd1, 1'b1};
    tbl[3]  = '{A_D,       4'd6, 4'd2, 1'b1};
    tbl[4]  = '{A_T,       4'd5, 4'd2, 1'b0};
    tbl[5]  = '{A_U,       4'd5, 4'd1, 1'b0};
    tbl[6]  = '{A_U,       4'd5, 4'd0, 1'b0};
    tbl[7]  = '{A_U,       4'd5, 4'd0, 1'b0};
    tbl[8]  = '{A_L,       4'd4, 4'd0, 1'b0};
    tbl[9]  = '{A_R | A_U, 4'd5, 4'd0, 1'b0};
    tbl[10] = '{A_L | A_D, 4'd4, 4'd0, 1'b0};
    tbl[11] = '{A_T | A_L, 4'd4, 4'd0, 1'b1};
    tbl[12] = '{A_D,       4'd4, 4'd1, 1'b1};
    tbl[13] = '{A_D,       4'd4, 4'd2, 1'b1};
    tbl[14] = '{A_D,       4'd4, 4'd3, 1'b1};
    tbl[15] = '{A_D,       4'd4, 4'd4, 1'b1};
    tbl[16] = '{A_D,       4'd4, 4'd5, 1'b1};
    tbl[17] = '{A_D,       4'd4, 4'd5, 1'b1};
    tbl[18] = '{A_T,       4'd4, 4'd5, 1'b0};
    tbl[19] = '{A_D,       4'd4, 4'd6, 1'b0};
    tbl[20] = '{A_D,       4'd4, 4'd7, 1'b0};
    tbl[21] = '{A_D,       4'd4, 4'd8, 1'b0};
    tbl[22] = '{A_D,       4'd4, 4'd9, 1'b0};
    tbl[23] = '{A_D,       4'd4, 4'd9, 1'b0};
    tbl[24] = '{A_T,       4'd4, 4'd5, 1'b1};
    tbl[25] = '{A_T,       4'd4, 4'd5, 1'b0};

    exp_ship = '0;
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < lens[r]; i++) exp_ship[r * 10 + i] = 1'b1;
    exp_g1 = '0;
    exp_g2 = '0;

    #3 RESET = 1'b0;
    tick();
    tick();
    chk("rst_update", 100'(UPDATE), 100'd0);
    chk("rst_boards", p1_ship | p1_guess | p2_ship | p2_guess, 100'd0);
    chk("rst_cursor", 100'({x_out, y_out, rotate}), 100'd0);
    chk("rst_flags", 100'({CHOOSE_SHIP, PLAYER1_MOVE, LAST_HIT, GAME_OVER, WINNER}), 100'b11000);
    chk("rst_len", 100'({p1_len, VALID_MOVE, P1_VALID, P2_VALID}), 100'({3'd5, 3'b110}));
    RESET = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) act(A_R);
    chk("right_sat_x", 100'(x_out), 100'd5);
    chk("right_updates", 100'(upd_seen), 100'd12);

    for (int i = 0; i < 26; i++) begin
      act(tbl[i].s);
      chk($sformatf("vec%0d_xyr", i), 100'({x_out, y_out, rotate}),
          100'({tbl[i].ex, tbl[i].ey, tbl[i].er}));
    end
    cur_x = 4;
    cur_y = 5;
    goto(0, 0);

    act(A_C);
    chk("p1_first_ship", p1_ship, 100'h1F);
    chk("p1_len_after_first", 100'(p1_len), 100'd4);
    act(A_T);
    chk("overlap_valid", 100'({P1_VALID, P2_VALID, VALID_MOVE}), 100'd0);
    act(A_C);
    chk("overlap_rejected", p1_ship, 100'h1F);
    chk("overlap_len", 100'({p1_len, CHOOSE_SHIP}), 100'({3'd4, 1'b1}));
    act(A_T);
    for (int r = 1; r < 5; r++) begin
      goto(0, r);
      act(A_C);
    end
    cur_x = 0;
    cur_y = 0;
    chk("p1_board", p1_ship, exp_ship);
    chk("p2_phase", 100'({CHOOSE_SHIP, PLAYER1_MOVE, x_out, y_out, rotate, p1_len, p2_len}),
        100'({1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 3'd5}));
    chk("p2_valid", 100'({P1_VALID, P2_VALID}), 100'b01);

    act(A_C);
    for (int r = 1; r < 5; r++) begin
      goto(0, r);
      act(A_C);
    end
    chk("p2_board", p2_ship, exp_ship);
    chk("popcounts", 100'({8'($countones(p1_ship)), 8'($countones(p2_ship))}), 100'({8'd17, 8'd17}));
    chk("fire_phase", 100'({CHOOSE_SHIP, PLAYER1_MOVE, p2_len}), 100'({1'b0, 1'b1, 3'd0}));

    goto(2, 0);
    chk("fresh_cell_valid", 100'(VALID_MOVE), 100'd1);
    act(A_C);
    exp_g1[2] = 1'b1;
    chk("p1_hit", 100'({LAST_HIT, PLAYER1_MOVE}), 100'b10);
    chk("p1_guess_hit", p1_guess, exp_g1);
    goto(9, 9);
    act(A_C);
    exp_g2[99] = 1'b1;
    chk("p2_miss", 100'({LAST_HIT, PLAYER1_MOVE}), 100'b01);
    chk("p2_guess_miss", p2_guess, exp_g2);
    goto(2, 0);
    chk("refire_invalid", 100'(VALID_MOVE), 100'd0);
    act(A_C);
    chk("refire_kept_turn", 100'({LAST_HIT, PLAYER1_MOVE}), 100'b01);
    chk("refire_guess", p1_guess, exp_g1);

    goto(3, 0);
    {CONFIRM, LEFT} = 2'b11;
    tick();
    {CONFIRM, LEFT} = 2'b00;
    chk("prio_update", 100'(UPDATE), 100'd1);
    RIGHT = 1'b1;
    tick();
    RIGHT = 1'b0;
    chk("wait_no_update", 100'(UPDATE), 100'd0);
    tick();
    FINISH = 1'b1;
    tick();
    FINISH = 1'b0;
    exp_g1[3] = 1'b1;
    chk("prio_cursor", 100'({x_out, y_out}), 100'({4'd3, 4'd0}));
    chk("prio_shot", 100'({LAST_HIT, PLAYER1_MOVE}), 100'b10);
    chk("prio_guess", p1_guess, exp_g1);

    for (int c = 0; c < 100; c++)
      if (exp_ship[c] && c != 2 && c != 3) p1t.push_back(c);
    for (int c = 80; c < 90; c++) p2t.push_back(c);
    for (int c = 70; c < 75; c++) p2t.push_back(c);
    for (int i = 0; i < 15; i++) begin
      goto(p2t[i] % 10, p2t[i] / 10);
      act(A_C);
      exp_g2[p2t[i]] = 1'b1;
      goto(p1t[i] % 10, p1t[i] / 10);
      act(A_C);
      exp_g1[p1t[i]] = 1'b1;
      if (i == 13) chk("not_over_at_16", 100'(GAME_OVER), 100'd0);
    end
    chk("game_over", 100'({GAME_OVER, WINNER, LAST_HIT, PLAYER1_MOVE}), 100'b1011);
    chk("final_g1", p1_guess, exp_g1);
    chk("final_g2", p2_guess, exp_g2);

    {CONFIRM, LEFT} = 2'b11;
    tick();
    {CONFIRM, LEFT} = 2'b00;
    chk("over_no_update", 100'(UPDATE), 100'd0);
    ROTATE_PRESS = 1'b1;
    FINISH = 1'b1;
    tick();
    ROTATE_PRESS = 1'b0;
    FINISH = 1'b0;
    chk("over_frozen", 100'({x_out, y_out, rotate, GAME_OVER}), 100'({4'(cur_x), 4'(cur_y), 1'b0, 1'b1}));
    chk("over_boards", p1_guess ^ p2_guess ^ p1_ship ^ p2_ship, exp_g1 ^ exp_g2);

    RESET = 1'b0;
    #2;
    chk("reset_clears", p1_ship | p1_guess | p2_ship | p2_guess, 100'd0);
    chk("reset_flags", 100'({GAME_OVER, LAST_HIT, PLAYER1_MOVE}), 100'b001);
    RESET = 1'b1;
    tick();
    act(A_C);
    chk("replace_first", p1_ship, 100'h1F);
    DOWN = 1'b1;
    tick();
    DOWN = 1'b0;
    chk("mid_wait_update", 100'(UPDATE), 100'd1);
    #2 RESET = 1'b0;
    #1;
    chk("mid_wait_reset", 100'({UPDATE, y_out, CHOOSE_SHIP}), 100'({1'b0, 4'd0, 1'b1}));
    chk("mid_wait_board", p1_ship, 100'd0);
    RESET = 1'b1;
    tick();
    chk("update_handshakes", 100'(bad_upd), 100'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
